mv_layer_sequencer: RTL
=======================

# mv_layer_sequencer

Sequences multi-layer matrix-vector passes on the parallel MV engine without per-layer PS intervention. Takes a layer count and go/abort bits from the AXI4-Lite control register, zeroes the y accumulator BRAMs before each pass, drives the engine's level-sensitive start/done handshake, and toggles a ping-pong bank select between layers. It sits between the AXI4-Lite register block and the engine's control/status pins, and owns the y-BRAM clear port through an external mux.

## Interface
- addr_y_size, 12, y BRAM byte-address width
- length_M, 128, output vector length
- P, 2, engine parallelism; y bank depth = length_M/P words
- LAYER_W, 8, layer counter width
- TIMEOUT_W, 20, watchdog width; timeout at 2^TIMEOUT_W-1 cycles
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ps_control  in  32  bit0 go (level), bit1 abort request
- ps_config  in  32  [LAYER_W-1:0] number of layers
- pl_status  out  32  bit0 done, bit1 busy, bit2 timeout error, bit3 aborted, [15:8] layers completed
- eng_start  out  1  to engine ps_control[0]
- eng_done  in  1  from engine pl_status[0]
- bank_sel  out  1  ping-pong buffer select, used externally as an address offset
- clr_active  out  1  selects the sequencer clear port onto both y BRAM ports
- clr_addr  out  addr_y_size  y clear byte address
- clr_we  out  4  y clear byte-write enable
- clr_wrdata  out  32  always 0

## Operation
- States: IDLE, CLEAR, RUN, RELEASE, NEXT, DONE, ERROR.
- IDLE → CLEAR when go=1 and the sampled count is nonzero. On this transition, latch num_layers from ps_config, set layer_cnt=0 and bank_sel=0, and clear the abort latch.
- IDLE → DONE when go=1 and the count is 0.
- CLEAR: one word per cycle at clr_addr = 0, 4, …, (length_M/P-1)*4, with clr_we=4'hf and clr_active=1. After the last word, go to RUN.
- RUN: eng_start=1 and the watchdog counts.
  - eng_done=1 → RELEASE.
  - Watchdog reaches its terminal value → ERROR.
- RELEASE: eng_start=0. Wait for eng_done=0, then go to NEXT.
- NEXT (single cycle): layer_cnt++ and bank_sel toggles.
  - → DONE if the new layer_cnt == num_layers or the abort latch is set.
  - Otherwise → CLEAR.
- DONE: hold done=1 while go=1. go=0 → IDLE.
- ERROR: eng_start=0 and status bit2=1. go=0 → IDLE; status bit2 is cleared on that exit.
- Abort (bit1) is latched in any state other than IDLE/DONE. It takes effect only at NEXT, because the engine cannot be stopped mid-pass. Aborting sets status bit3.
- Status bits 3 and [15:8] hold their values through DONE/ERROR and clear on the transition into CLEAR or DONE from IDLE.
- busy = state ∉ {IDLE, DONE, ERROR}.
- Changes to ps_config after go is sampled have no effect.

## Timing
- Reset values of all outputs: pl_status=0, eng_start=0, bank_sel=0, clr_active=0, clr_addr=0, clr_we=0, clr_wrdata=0. State=IDLE, counters=0.
- All outputs are decoded from registered state and counters. There is no combinational path from an input to an output.
- go sampled in cycle t → CLEAR in cycle t+1 with clr_addr=0. CLEAR lasts exactly length_M/P cycles (64 at defaults).
- eng_start rises in the first RUN cycle. eng_done sampled high in cycle t → eng_start=0 in cycle t+1.
- Per-layer overhead beyond the engine run: length_M/P + 2 + the engine release latency (1 cycle).
- Watchdog:
  - Cleared on entry to RUN.
  - Saturates at the timeout and does not wrap.
  - A timeout and eng_done arriving in the same cycle resolve as done.
- Reset mid-operation drops eng_start in the next cycle.
- A layer_cnt of 2^LAYER_W-1 layers is supported with no wrap-around.
- go deasserted while busy is ignored; the sequence runs to completion.
- Abort asserted in the same cycle as NEXT is not seen until the next NEXT.

## Structure
- Package mv_ctrl_pkg holds:
  - the state enum;
  - pl_status bit positions (DONE_BIT=0, BUSY_BIT=1, TMO_BIT=2, ABORT_BIT=3, LCNT_LSB=8);
  - the go/abort bit indices.
- Sub-module y_clear_gen generates the clear addresses. Its ports are start, addr, we and last, and its depth is length_M/P.
- The FSM, watchdog and layer counter are in the top module.

## Test plan
- Config 3, go=1, engine model with done after 200 cycles:
  - three clear bursts of 64 words each;
  - three start/done handshakes;
  - bank_sel sequence 0,1,0, ending at 1;
  - pl_status = 0x0301 while go held; go=0 → 0x0000 next cycle.
- Config 0, go=1: done within 2 cycles, no clr_we, eng_start never asserted.
- Config 4, abort pulsed during layer 2's RUN: layer 2 completes, then DONE with pl_status[15:8]=2 and bit3=1.
- TIMEOUT_W=6, engine never asserts done: ERROR at cycle 63 of RUN, eng_start=0, pl_status bit2=1; go=0 → IDLE.
- reset asserted mid-CLEAR at clr_addr=0x40: next cycle all outputs are 0 and state is IDLE; a fresh go restarts at clr_addr=0.
- eng_done held high 5 extra cycles after eng_start falls: the sequencer stays in RELEASE, then proceeds to NEXT one cycle after done drops.

Source files
------------

// File: rtl/mv_ctrl_pkg.sv
// Shared definitions for the multi-layer MV sequencer: FSM states,
// pl_status bit layout and ps_control bit indices.
package mv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RUN     = 3'd2,
    ST_RELEASE = 3'd3,
    ST_NEXT    = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERROR   = 3'd6
  } seq_state_e;

  // pl_status layout
  localparam int DONE_BIT  = 0;
  localparam int BUSY_BIT  = 1;
  localparam int TMO_BIT   = 2;
  localparam int ABORT_BIT = 3;
  localparam int LCNT_LSB  = 8;
  localparam int LCNT_W    = 8;

  // ps_control layout
  localparam int GO_BIT        = 0;
  localparam int ABORT_REQ_BIT = 1;

  // The sequencer is busy whenever it owns the engine or the y BRAMs.
  function automatic logic is_busy(input seq_state_e s);
    return !(s inside {ST_IDLE, ST_DONE, ST_ERROR});
  endfunction

endpackage

// File: rtl/mv_layer_sequencer_y_clear_gen.sv
// Walks the y accumulator bank once, one 32-bit word per cycle, writing
// zeros. A start pulse launches a burst; last flags the final word.
module y_clear_gen #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] addr,
  output logic [3:0]        we,
  output logic              last
);

  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             active_q;

  // Word counter: restarts on start, stops itself after the last word.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start) begin
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_q    <= '0;
        active_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Byte address of the current word; counter returns to 0 when idle.
  assign addr = ADDR_W'({cnt_q, 2'b00});
  assign we   = {4{active_q}};
  assign last = active_q && (cnt_q == CNT_LAST);

endmodule

// File: rtl/mv_layer_sequencer.sv
// Runs N back-to-back matrix-vector passes on the MV engine: clears the
// y bank, hands the engine a level start, waits for its done/release
// handshake and flips the ping-pong bank between layers. Abort is only
// honoured between layers since the engine cannot be stopped mid-pass.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for go; latches layer count on go
// CLEAR   | zeroing the y bank, one word per cycle
// RUN     | eng_start high, watchdog counting
// RELEASE | eng_start low, waiting for engine to drop done
// NEXT    | one cycle: bump layer count, flip bank, pick next state
// DONE    | sequence complete, held until go drops
// ERROR   | watchdog expired, held until go drops
module mv_layer_sequencer
  import mv_ctrl_pkg::*;
#(
  parameter int addr_y_size = 12,
  parameter int length_M    = 128,
  parameter int P           = 2,
  parameter int LAYER_W     = 8,
  parameter int TIMEOUT_W   = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            ps_control,
  input  logic [31:0]            ps_config,
  output logic [31:0]            pl_status,
  output logic                   eng_start,
  input  logic                   eng_done,
  output logic                   bank_sel,
  output logic                   clr_active,
  output logic [addr_y_size-1:0] clr_addr,
  output logic [3:0]             clr_we,
  output logic [31:0]            clr_wrdata
);

  localparam int DEPTH = length_M / P;
  localparam logic [TIMEOUT_W-1:0] WDOG_MAX = '1;

  seq_state_e         state_q;
  logic [LAYER_W-1:0] num_layers_q;
  logic [LAYER_W-1:0] layer_cnt_q;
  logic [TIMEOUT_W-1:0] wdog_q;
  logic               bank_q;
  logic               abort_q;
  logic               aborted_q;

  logic               go;
  logic               abort_req;
  logic [LAYER_W-1:0] cfg_layers;
  logic [LAYER_W-1:0] layer_cnt_inc;
  logic               seq_finish;
  logic               clr_start;
  logic               clr_last;
  logic               unused_ok;

  assign go            = ps_control[GO_BIT];
  assign abort_req     = ps_control[ABORT_REQ_BIT];
  assign cfg_layers    = ps_config[LAYER_W-1:0];
  assign unused_ok     = ^{ps_control[31:2], ps_config[31:LAYER_W]};

  // layer_cnt_q < num_layers_q whenever NEXT is reached, so this never wraps.
  assign layer_cnt_inc = layer_cnt_q + 1'b1;
  assign seq_finish    = (layer_cnt_inc == num_layers_q) || abort_q;

  // Kick the clear generator on every transition into CLEAR.
  assign clr_start = ((state_q == ST_IDLE) && go && (cfg_layers != '0)) ||
                     ((state_q == ST_NEXT) && !seq_finish);

  y_clear_gen #(
    .DEPTH  (DEPTH),
    .ADDR_W (addr_y_size)
  ) u_y_clear_gen (
    .clk   (clk),
    .reset (reset),
    .start (clr_start),
    .addr  (clr_addr),
    .we    (clr_we),
    .last  (clr_last)
  );

  // Sequencer FSM with layer counter, bank toggle, watchdog and abort latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      num_layers_q <= '0;
      layer_cnt_q  <= '0;
      wdog_q       <= '0;
      bank_q       <= 1'b0;
      abort_q      <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      // Latched in any active state; NEXT reads the pre-update value, so an
      // abort landing in NEXT itself waits for the following layer boundary.
      if (abort_req && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
        abort_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (go) begin
            num_layers_q <= cfg_layers;
            layer_cnt_q  <= '0;
            bank_q       <= 1'b0;
            abort_q      <= 1'b0;
            aborted_q    <= 1'b0;
            state_q      <= (cfg_layers != '0) ? ST_CLEAR : ST_DONE;
          end
        end

        ST_CLEAR: begin
          if (clr_last) begin
            wdog_q  <= '0;
            state_q <= ST_RUN;
          end
        end

        ST_RUN: begin
          // done wins over a coincident timeout
          if (eng_done) begin
            state_q <= ST_RELEASE;
          end else if (wdog_q == WDOG_MAX) begin
            state_q <= ST_ERROR;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end

        ST_RELEASE: begin
          if (!eng_done) begin
            state_q <= ST_NEXT;
          end
        end

        ST_NEXT: begin
          layer_cnt_q <= layer_cnt_inc;
          bank_q      <= ~bank_q;
          if (seq_finish) begin
            aborted_q <= abort_q;
            state_q   <= ST_DONE;
          end else begin
            state_q   <= ST_CLEAR;
          end
        end

        ST_DONE: begin
          if (!go) begin
            state_q <= ST_IDLE;
          end
        end

        ST_ERROR: begin
          if (!go) begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign eng_start  = (state_q == ST_RUN);
  assign bank_sel   = bank_q;
  assign clr_active = (state_q == ST_CLEAR);
  assign clr_wrdata = '0;

  // Status is a pure decode of registers. The result fields are kept in
  // their registers until the next go, but read as zero once back in IDLE
  // so software sees a clean status after releasing go.
  always_comb begin
    pl_status                      = '0;
    pl_status[DONE_BIT]            = (state_q == ST_DONE);
    pl_status[BUSY_BIT]            = is_busy(state_q);
    pl_status[TMO_BIT]             = (state_q == ST_ERROR);
    pl_status[ABORT_BIT]           = aborted_q && (state_q != ST_IDLE);
    pl_status[LCNT_LSB +: LCNT_W]  = (state_q == ST_IDLE) ? '0 : LCNT_W'(layer_cnt_q);
  end

endmodule
